sys_array_sequencer: RTL
========================

SYS_ARRAY_SEQUENCER -- requirements
Module: sys_array_sequencer

Interface
REQ-001 SHALL have parameter ARRAY_A_W, default 4, number of result rows.
REQ-002 SHALL have parameter ARRAY_W_L, default 4, number of result columns.
REQ-003 SHALL have parameter TIMEOUT, default 1023, maximum WAIT cycles before error (range 1..65535).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  input  1  host job request, level, sampled in IDLE only.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse, job completed.
REQ-009 SHALL have port err  output  1  one-cycle pulse, compute timeout.
REQ-010 SHALL have port weights_load  output  1  one-cycle pulse to datapath, load weights.
REQ-011 SHALL have port start_comp  output  1  one-cycle pulse to datapath, start computation.
REQ-012 SHALL have port ready  input  1  datapath result-valid level.
REQ-013 SHALL have port rd_row  output  4  result row index.
REQ-014 SHALL have port rd_col  output  4  result column index.
REQ-015 SHALL have port rd_valid  output  1  rd_row/rd_col present a valid result address.
REQ-016 SHALL have port rd_ready  input  1  consumer accepts the current address.

Function
REQ-017 SHALL implement states IDLE, LOAD, COMP, WAIT, READ, DONE, ERR.
REQ-018 IDLE: req=1 at an edge -> LOAD next cycle; req=0 -> stay IDLE.
REQ-019 LOAD: weights_load=1 for exactly this one cycle; -> COMP unconditionally.
REQ-020 COMP: start_comp=1 for exactly this one cycle; -> WAIT; WAIT counter cleared to 0.
REQ-021 WAIT: SHALL detect a ready rising edge (ready=1 and registered previous ready=0); on that edge -> READ with rd_row=0, rd_col=0.
REQ-022 WAIT: counter increments each cycle without a rising edge; when counter reaches TIMEOUT -> ERR; a rising edge on the same cycle the counter reaches TIMEOUT takes priority (-> READ).
REQ-023 A ready level already high on WAIT entry SHALL NOT count as completion; the datapath must drop and re-raise ready.
REQ-024 READ: rd_valid=1; the address advances only on rd_valid and rd_ready both high; order is row-major: rd_col increments, then wraps to 0 with rd_row+1.
REQ-025 READ: rd_row/rd_col SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-026 READ: a handshake at (ARRAY_A_W-1, ARRAY_W_L-1) -> DONE; rd_valid=0 from the next cycle.
REQ-027 DONE: done=1 for one cycle; -> IDLE.
REQ-028 ERR: err=1 for one cycle; -> IDLE; no readout is performed.
REQ-029 req while busy=1 SHALL be ignored, not queued; a req held high through DONE starts a new job from IDLE on the following cycle.
REQ-030 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-031 Job latency, req to weights_load: 1 cycle; ready edge to first rd_valid: 1 cycle.

Reset
REQ-032 reset=1 SHALL asynchronously force state IDLE, counter 0, ready history 0, rd_row=0, rd_col=0, and busy, done, err, weights_load, start_comp and rd_valid all 0.
REQ-033 Reset asserted in any state, including mid-READ, SHALL abort the job with no done/err pulse; operation resumes at the first edge after deassertion.

Verification
REQ-034 Nominal: defaults, req pulse, ready rises 20 cycles after start_comp, rd_ready=1 -> weights_load, start_comp each exactly 1 cycle; 16 addresses (0,0)..(3,3) row-major on consecutive cycles; done 1 cycle after (3,3).
REQ-035 Backpressure: rd_ready toggled 1010... in READ -> each address held until accepted; still 16 unique addresses; done once.
REQ-036 Timeout: TIMEOUT=8, ready held 0 -> err pulse exactly 8 WAIT cycles after COMP; busy falls with it; no rd_valid.
REQ-037 Stale ready: ready=1 before req and held -> no READ entry; a drop and then a rise -> READ 1 cycle after the rise.
REQ-038 Reset mid-READ at address (2,1) -> all outputs 0 asynchronously; no done; a new req then runs a complete job.
REQ-039 Held req: req high for 100 cycles, ready edge supplied -> back-to-back jobs, one IDLE cycle between done and the next weights_load, no req sampled while busy.

Source files
------------

// File: rtl/sys_array_sequencer.sv
// Job sequencer for a systolic array: load weights, start compute, wait for a fresh ready edge, stream result addresses.
// Every output is registered. The readout address advances only on rd_valid && rd_ready.
module sys_array_sequencer #(
    parameter int ARRAY_A_W = 4,
    parameter int ARRAY_W_L = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       weights_load,
    output logic       start_comp,
    input  logic       ready,
    output logic [3:0] rd_row,
    output logic [3:0] rd_col,
    output logic       rd_valid,
    input  logic       rd_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMP,
        S_WAIT,
        S_READ,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0]  ROW_LAST = 4'(ARRAY_A_W - 1);
    localparam logic [3:0]  COL_LAST = 4'(ARRAY_W_L - 1);
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        ready_q;
    logic        ready_rise;

    // ready_q tracks ready in every state, so a level that is already high on WAIT entry never looks like an edge.
    assign ready_rise = ready & ~ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            weights_load <= 1'b0;
            start_comp   <= 1'b0;
            rd_row       <= '0;
            rd_col       <= '0;
            rd_valid     <= 1'b0;
        end else begin
            ready_q      <= ready;
            weights_load <= 1'b0;
            start_comp   <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        state_q      <= S_LOAD;
                        busy         <= 1'b1;
                        weights_load <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state_q    <= S_COMP;
                    start_comp <= 1'b1;
                end
                S_COMP: begin
                    state_q <= S_WAIT;
                    cnt_q   <= '0;
                end
                S_WAIT: begin
                    // A ready edge on the final WAIT cycle still wins over the timeout.
                    if (ready_rise) begin
                        state_q  <= S_READ;
                        rd_row   <= '0;
                        rd_col   <= '0;
                        rd_valid <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_ERR;
                        err     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_READ: begin
                    if (rd_ready) begin
                        if (rd_col != COL_LAST) begin
                            rd_col <= rd_col + 4'd1;
                        end else if (rd_row != ROW_LAST) begin
                            rd_col <= '0;
                            rd_row <= rd_row + 4'd1;
                        end else begin
                            state_q  <= S_DONE;
                            rd_valid <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    busy     <= 1'b0;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
